shift_cmd_sequencer: RTL
========================

Name: shift_cmd_sequencer

Overview:
- Upstream control stage for the 8-bit left shifter, which is combinational, takes an 8-bit operand and a 3-bit select, and shifts by at most 7 per pass.
- Accepts shift commands over a valid/ready handshake and splits amounts wider than 7 into successive passes.
- Drives the shifter operand and select each pass, then registers the shifter output back into a working register.
- Presents the final result downstream over a valid/ready handshake.

Parameters:
- AMT_W, 5, width of the command shift amount; legal amounts are 0 to 2^AMT_W-1.
- STEP_MAX, 7, largest amount per pass. Fixed by the 3-bit shifter select; not to be overridden.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_data  in  8  operand to shift.
- cmd_amt  in  AMT_W  total left-shift amount.
- sh_a  out  8  operand to the shifter's a input, equal to the working register.
- sh_sel  out  3  select to the shifter's {s2,s1,s0}; value is this pass's shift amount.
- sh_o  in  8  shifter output o, combinational from sh_a/sh_sel.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_data  out  8  result, equal to the working register.
- busy  out  1  high in SHIFT or DONE.
- pass_cnt  out  3  number of passes done for the current command; saturates at 7.

Behaviour:
- Reset:
  - The reset condition is synchronous and active-high.
  - rst=1 at a rising edge forces state=IDLE, work=0, rem=0, pass_cnt=0.
  - As a result, cmd_ready=1, res_valid=0, busy=0, res_data=0, sh_a=0, sh_sel=0.
  - Reset mid-command drops the command silently; no result is produced.
- Registers:
  - work: 8 bits.
  - rem: AMT_W bits.
  - pass_cnt: 3 bits.
  - state: one of IDLE, SHIFT, DONE.
- Step definition: step = (rem > 7) ? 7 : rem[2:0].
- sh_sel:
  - Equals step in SHIFT, and 0 in IDLE and DONE.
  - sh_a = work at all times.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: work<=cmd_data, rem<=cmd_amt, pass_cnt<=0.
  - Next state is DONE if cmd_amt==0, else SHIFT.
- SHIFT:
  - cmd_ready=0.
  - Each cycle: work<=sh_o, rem<=rem-step, pass_cnt<=pass_cnt+1 (saturating).
  - When rem-step==0, next state is DONE; otherwise stay in SHIFT.
  - The sequencer never samples sh_o outside SHIFT.
- DONE:
  - res_valid=1, holding res_data and pass_cnt stable until accepted.
  - On res_ready: go to IDLE with res_valid=0.
  - cmd_ready stays 0 in DONE, so there is no same-cycle accept of a new command.
- Latency:
  - From the accepting cycle to res_valid: 1 + ceil(cmd_amt/7) cycles.
  - amt=0 gives 1 cycle; amt=7 gives 2; amt=8 gives 3; amt=31 gives 6.
- Throughput: one command per (latency + 1) cycles when res_ready is held 1.
- Amounts of 8 or more: the result is whatever the chained passes produce, with no shortcut to zero. This keeps the result bit-exact with the shifter.
- Handshake rules:
  - cmd_data and cmd_amt are sampled only on cmd_valid & cmd_ready.
  - cmd_valid while not ready is ignored; no buffering.
  - res_valid, once raised, is never withdrawn before res_ready, except by rst.
- Arithmetic:
  - rem never underflows, because step ≤ rem.
  - pass_cnt saturates at 7. This is unreachable with AMT_W=5, since the maximum is 5 passes, but it is specified for wider AMT_W.
- Simultaneous events:
  - rst has priority over every transition.
  - cmd_valid during DONE has no effect.

Test Plan (bench model for the shifter: sh_o = (sh_a << sh_sel) & 8'hFF):
- rst held for 2 cycles, then released → cmd_ready=1, res_valid=0, busy=0, res_data=8'h00, sh_sel=0.
- cmd {data=8'hA5, amt=0} with res_ready=1 → res_valid one cycle after accept, res_data=8'hA5, pass_cnt=0, then IDLE.
- cmd {8'h01, amt=3} → one SHIFT cycle with sh_sel=3, sh_a=8'h01 → res_data=8'h08, pass_cnt=1, latency 2.
- cmd {8'h01, amt=10} → SHIFT passes with sh_sel 7 then 3, sh_a 8'h01 then 8'h80 → res_data=8'h00, pass_cnt=2, latency 3.
- cmd {8'h81, amt=1}, res_ready held 0 for 5 cycles → res_valid=1 with res_data=8'h02 held stable throughout. A cmd_valid pulse meanwhile is not accepted (cmd_ready=0). res_ready=1 → IDLE next cycle.
- cmd {8'hFF, amt=31}, rst asserted on the 3rd SHIFT cycle → next cycle IDLE, res_valid never seen, work=0. A fresh cmd {8'h03, amt=2} then yields 8'h0C.

Source files
------------

// File: rtl/shift_cmd_sequencer.sv
// Control stage in front of the 8-bit combinational left shifter.
// Takes a shift command (operand + total amount), splits the amount into
// passes of at most 7, drives the shifter once per pass and folds the
// shifter output back into the working register, then offers the result.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. Once raised, res_valid stays high with res_data/pass_cnt
// stable until res_ready is seen (only rst can withdraw it). cmd_valid
// while cmd_ready is low is ignored; nothing is buffered.
module shift_cmd_sequencer #(
  parameter int AMT_W    = 5,
  parameter int STEP_MAX = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_data,
  input  logic [AMT_W-1:0] cmd_amt,
  output logic [7:0]       sh_a,
  output logic [2:0]       sh_sel,
  input  logic [7:0]       sh_o,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             busy,
  output logic [2:0]       pass_cnt,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       work_q, work_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       pass_q, pass_d;

  logic [2:0]       step;
  logic [AMT_W-1:0] rem_sub;

  // Amount to apply this pass: the whole remainder if it fits the 3-bit
  // select, otherwise the largest single pass.
  always_comb begin
    step = rem_q[2:0];
    if (rem_q > AMT_W'(STEP_MAX)) begin
      step = 3'(STEP_MAX);
    end
    rem_sub = rem_q - AMT_W'(step);
  end

  // Next-state logic for the IDLE -> SHIFT* -> DONE sequence.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          work_d  = cmd_data;
          rem_d   = cmd_amt;
          pass_d  = 3'd0;
          state_d = (cmd_amt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        // sh_o is only consumed here, while sh_sel carries a real step.
        work_d = sh_o;
        rem_d  = rem_sub;
        if (pass_q != 3'd7) begin
          pass_d = pass_q + 3'd1;
        end
        if (rem_sub == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset wins over any transition in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= 8'h00;
      rem_q   <= '0;
      pass_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      pass_q  <= pass_d;
    end
  end

  // Outputs are pure decodes of the registered state.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    res_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    sh_a      = work_q;
    sh_sel    = (state_q == S_SHIFT) ? step : 3'd0;
    res_data  = work_q;
    pass_cnt  = pass_q;
    dbg_state = state_q;
  end

endmodule
